// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared pipelined memory between the I-cache fill path and the D-cache fill/store path.
// Issues one line fill (BLOCK_WORDS sequential reads) or one store word per grant and tags returned words.
module mem_fill_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LAT     = 4,
    parameter int BLOCK_WORDS = 8,
    parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_data_vld,
    output logic [DATA_W-1:0] i_data,
    output logic [IDX_W-1:0]  i_word,
    output logic              i_done,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_data_vld,
    output logic [DATA_W-1:0] d_data,
    output logic [IDX_W-1:0]  d_word,
    output logic              d_done,

    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // r_own_d doubles as last_gnt: it only changes when a new grant is made
    logic               r_own_d;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [IDX_W-1:0]   r_iss;
    logic [IDX_W-1:0]   r_ret;
    logic [MEM_LAT-1:0] r_vld_sr;

    logic               r_i_gnt;
    logic               r_i_vld_p1;
    logic [DATA_W-1:0]  r_i_data_p1;
    logic [IDX_W-1:0]   r_i_word_p1;
    logic               r_i_done_p1;
    logic               r_d_gnt;
    logic               r_d_vld_p1;
    logic [DATA_W-1:0]  r_d_data_p1;
    logic [IDX_W-1:0]   r_d_word_p1;
    logic               r_d_done_p1;

    logic               w_any;
    logic               w_pick_d;
    logic               w_grant;
    logic               w_own_nxt;
    logic               w_rd_issue;
    logic               w_ret;
    logic               w_ret_last;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // On a tie the side that did not win last time gets the memory
    assign w_any      = i_req | d_req;
    assign w_pick_d   = d_req & (~i_req | ~r_own_d);
    assign w_grant    = (r_state == S_IDLE) & w_any;
    assign w_own_nxt  = w_grant ? w_pick_d : r_own_d;
    assign w_ret      = r_vld_sr[MEM_LAT-1];
    assign w_ret_last = w_ret & (r_ret == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = (w_pick_d && d_wr) ? S_WRITE : S_FILL;
                end
            end
            S_FILL: begin
                if (r_iss == LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_i_done_p1 || r_d_done_p1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        w_rd_issue = 1'b0;
        case (r_state)
            S_FILL: begin
                mem_en     = 1'b1;
                w_rd_issue = 1'b1;
                mem_addr   = {r_addr[ADDR_W-1:OFF_W], r_iss, 1'b0};
            end
            S_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own_d <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_iss   <= '0;
            r_i_gnt <= 1'b0;
            r_d_gnt <= 1'b0;
        end else begin
            if (w_grant) begin
                r_own_d <= w_pick_d;
                r_addr  <= w_pick_d ? (d_wr ? d_addr : line_base(d_addr)) : line_base(i_addr);
                r_wdata <= d_wdata;
            end
            if (r_state == S_FILL) begin
                r_iss <= r_iss + IDX_W'(1);
            end
            r_i_gnt <= (w_state_nxt != S_IDLE) & ~w_own_nxt;
            r_d_gnt <= (w_state_nxt != S_IDLE) & w_own_nxt;
        end
    end

    // Return stage p1: mem_rdata is registered together with its valid and word index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr    <= '0;
            r_ret       <= '0;
            r_i_vld_p1  <= 1'b0;
            r_i_data_p1 <= '0;
            r_i_word_p1 <= '0;
            r_i_done_p1 <= 1'b0;
            r_d_vld_p1  <= 1'b0;
            r_d_data_p1 <= '0;
            r_d_word_p1 <= '0;
            r_d_done_p1 <= 1'b0;
        end else begin
            r_vld_sr[0] <= w_rd_issue;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_vld_sr[k] <= r_vld_sr[k-1];
            end
            if (w_ret) begin
                r_ret <= r_ret + IDX_W'(1);
            end
            r_i_vld_p1  <= w_ret & ~r_own_d;
            r_i_data_p1 <= (w_ret & ~r_own_d) ? mem_rdata : '0;
            r_i_word_p1 <= (w_ret & ~r_own_d) ? r_ret : '0;
            r_i_done_p1 <= w_ret_last & ~r_own_d;
            r_d_vld_p1  <= w_ret & r_own_d;
            r_d_data_p1 <= (w_ret & r_own_d) ? mem_rdata : '0;
            r_d_word_p1 <= (w_ret & r_own_d) ? r_ret : '0;
            r_d_done_p1 <= (w_ret_last & r_own_d) | (w_state_nxt == S_WRITE);
        end
    end

    assign i_gnt      = r_i_gnt;
    assign i_data_vld = r_i_vld_p1;
    assign i_data     = r_i_data_p1;
    assign i_word     = r_i_word_p1;
    assign i_done     = r_i_done_p1;
    assign d_gnt      = r_d_gnt;
    assign d_data_vld = r_d_vld_p1;
    assign d_data     = r_d_data_p1;
    assign d_word     = r_d_word_p1;
    assign d_done     = r_d_done_p1;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter: stimulus queues expected reads, writes and returned words;
// a negedge monitor pops and compares them whenever the DUT shows activity.
module tb_mem_fill_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 4;
    localparam int BW      = 8;
    localparam int IDX_W   = 3;

    logic              clk;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_data_vld;
    logic [DATA_W-1:0] i_data;
    logic [IDX_W-1:0]  i_word;
    logic              i_done;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_data_vld;
    logic [DATA_W-1:0] d_data;
    logic [IDX_W-1:0]  d_word;
    logic              d_done;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_fill_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .BLOCK_WORDS(BW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_vld(i_data_vld),
        .i_data(i_data), .i_word(i_word), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_data_vld(d_data_vld), .d_data(d_data), .d_word(d_word), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: read data appears MEM_LAT cycles after the issue cycle, garbage otherwise
    logic [MEM_LAT-1:0] pv = '0;
    logic [15:0]        pa [MEM_LAT];
    always @(posedge clk) begin
        pv[0] <= mem_en & ~mem_wr;
        pa[0] <= mem_addr;
        for (int k = 1; k < MEM_LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end
    assign mem_rdata = pv[MEM_LAT-1] ? mem_f(pa[MEM_LAT-1]) : 16'hDEAD;

    typedef struct {
        int          cyc;
        bit          side;
        logic [15:0] addr;
    } rd_t;
    typedef struct {
        int          cyc;
        bit          side;
        logic [15:0] data;
        logic [2:0]  word;
        bit          done;
    } ret_t;
    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    rd_t  q_rd[$];
    ret_t q_ret[$];
    wr_t  q_wr[$];
    rd_t  m_rd;
    ret_t m_ret;
    wr_t  m_wr;

    int checks   = 0;
    int failures = 0;

    logic [77:0] all_out;
    assign all_out = {i_gnt, i_data_vld, i_data, i_word, i_done,
                      d_gnt, d_data_vld, d_data, d_word, d_done,
                      mem_en, mem_wr, mem_addr, mem_wdata};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int detail);
        checks++;
        failures++;
        $display("FAIL %s: got event, expected none (info=%0d, cycle %0d)", name, detail, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
                flag("rd_missed", q_rd[0].cyc);
                q_rd.delete(0);
            end
            while (q_ret.size() > 0 && q_ret[0].cyc < cyc) begin
                flag("ret_missed", q_ret[0].cyc);
                q_ret.delete(0);
            end
            while (q_wr.size() > 0 && q_wr[0].cyc < cyc) begin
                flag("wr_missed", q_wr[0].cyc);
                q_wr.delete(0);
            end

            chk("both_gnt", i_gnt & d_gnt, 0);

            if (mem_en && !mem_wr) begin
                if (q_rd.size() == 0) begin
                    flag("rd_unexpected", int'(mem_addr));
                end else begin
                    m_rd = q_rd.pop_front();
                    chk("rd_cyc", cyc, m_rd.cyc);
                    chk("rd_addr", mem_addr, m_rd.addr);
                    chk("rd_gnt", m_rd.side ? d_gnt : i_gnt, 1);
                end
            end else if (mem_en && mem_wr) begin
                if (q_wr.size() == 0) begin
                    flag("wr_unexpected", int'(mem_addr));
                end else begin
                    m_wr = q_wr.pop_front();
                    chk("wr_cyc", cyc, m_wr.cyc);
                    chk("wr_addr", mem_addr, m_wr.addr);
                    chk("wr_data", mem_wdata, m_wr.data);
                    chk("wr_done_gnt", {d_done, d_gnt, d_data_vld}, 3'b110);
                end
            end else begin
                chk("idle_bus", {mem_wr, mem_addr, mem_wdata}, 0);
            end

            if (i_data_vld || d_data_vld) begin
                if (q_ret.size() == 0) begin
                    flag("ret_unexpected", int'({i_data_vld, d_data_vld}));
                end else begin
                    m_ret = q_ret.pop_front();
                    chk("ret_cyc", cyc, m_ret.cyc);
                    chk("ret_side", {d_data_vld, i_data_vld}, m_ret.side ? 2'b10 : 2'b01);
                    chk("ret_data", m_ret.side ? d_data : i_data, m_ret.data);
                    chk("ret_word", m_ret.side ? d_word : i_word, m_ret.word);
                    chk("ret_done", m_ret.side ? d_done : i_done, m_ret.done);
                    chk("ret_gnt", m_ret.side ? d_gnt : i_gnt, 1);
                end
            end
            if (!i_data_vld) chk("i_quiet", {i_data, i_word, i_done}, 0);
            if (!d_data_vld) chk("d_quiet", {d_data, d_word}, 0);
            if (!d_data_vld && !(mem_en && mem_wr)) chk("d_done_stray", d_done, 0);
        end
    end

    task automatic push_fill(input bit side, input logic [15:0] addr, input int t0);
        rd_t         r;
        ret_t        e;
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < BW; k++) begin
            r.cyc  = t0 + 1 + k;
            r.side = side;
            r.addr = base + 16'(2 * k);
            q_rd.push_back(r);
            e.cyc  = t0 + 6 + k;
            e.side = side;
            e.data = mem_f(base + 16'(2 * k));
            e.word = 3'(k);
            e.done = (k == BW - 1);
            q_ret.push_back(e);
        end
    endtask

    task automatic wait_done(input bit side, input int drop_at);
        bit seen;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (n == drop_at) begin
                if (side) d_req = 1'b0;
                else      i_req = 1'b0;
            end
            if (side ? d_done : i_done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        if (side) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    task automatic do_fill(input bit side, input logic [15:0] addr, input int drop_at);
        int t0;
        @(negedge clk);
        t0 = cyc;
        push_fill(side, addr, t0);
        if (side) begin
            d_req  = 1'b1;
            d_wr   = 1'b0;
            d_addr = addr;
        end else begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        wait_done(side, drop_at);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        wr_t w;
        @(negedge clk);
        w.cyc  = cyc + 1;
        w.addr = addr;
        w.data = data;
        q_wr.push_back(w);
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = addr;
        d_wdata = data;
        @(negedge clk);
        chk("wr_done_pulse", d_done, 1);
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_wdata = '0;
        @(negedge clk);
        chk("wr_back_idle", {i_gnt, d_gnt, mem_en, d_done}, 0);
    endtask

    initial begin
        int t0;
        int cnt;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out, 0);

        // Both sides requesting from reset release: D, I, D, I
        @(negedge clk);
        rst_n  = 1'b1;
        i_req  = 1'b1;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        i_addr = 16'h0104;
        d_addr = 16'h020A;
        t0 = cyc;
        for (int n = 0; n < 4; n++) begin
            push_fill(n % 2 == 0, (n % 2 == 0) ? 16'h020A : 16'h0104, t0 + 14 * n);
        end
        cnt = 0;
        for (int n = 0; n < 100 && cnt < 4; n++) begin
            @(negedge clk);
            if (i_done || d_done) cnt++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk("arb_fill_count", cnt, 4);

        do_fill(1'b0, 16'h1236, 0);
        do_write(16'h0040, 16'hBEEF);
        do_fill(1'b1, 16'h00F8, 0);
        do_fill(1'b1, 16'h0300, 3);

        // Reset in the middle of a fill
        @(negedge clk);
        t0 = cyc;
        push_fill(1'b0, 16'h1000, t0);
        i_req  = 1'b1;
        i_addr = 16'h1000;
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 3; n++) begin
            @(negedge clk);
            if (i_data_vld) cnt++;
        end
        chk("pre_reset_vld", cnt, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        i_req = 1'b0;
        q_rd.delete();
        q_ret.delete();
        q_wr.delete();
        #1;
        chk("midburst_reset_outputs", all_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_fill(1'b0, 16'h2000, 0);

        repeat (10) @(negedge clk);
        chk("q_rd_left", q_rd.size(), 0);
        chk("q_ret_left", q_ret.size(), 0);
        chk("q_wr_left", q_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
